rv32i_ldst_top: RTL and testbench
=================================

# rv32i_ldst_top

Self-contained RV32I load/store verification top: a single-cycle integer core with its own program memory and data memory. Benches use it as the unit under test for LUI, AUIPC, ADDI, loads and stores. Both memories are preloaded by hierarchical `$readmemb`/`$readmemh` access. Results are checked through a register-file debug port and the data memory contents.

## Interface
- `PROG_WORDS`, 256: program memory depth in 32-bit words (power of 2).
- `DATA_WORDS`, 256: data memory depth in 32-bit words (power of 2).
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `dbg_sel`  in  5  register-file index for the debug read.
- `dbg_data`  out  32  combinational read of `x[dbg_sel]`; reads 0 when `dbg_sel`=0.
- `pc`  out  32  current PC.
- `illegal`  out  1  high while the fetched instruction is unsupported.

Memory instance paths are fixed for bench loading:
- program memory: `mem_prog_inst.progArray[0:PROG_WORDS-1]`, 32 bits, word-indexed.
- data memory: `mem_data_inst.dataArray[0:DATA_WORDS-1]`, 32 bits, word-indexed, little-endian bytes.

## Operation
- Fetch: `instr = progArray[pc[log2(PROG_WORDS)+1:2]]`. Program memory is read-only to the core.
- Register file: 32×32. `x0` reads 0 and ignores writes. Two combinational read ports plus the debug port; one write port.
- Supported instructions:
  - LUI: `rd = {imm[31:12], 12'b0}`.
  - AUIPC: `rd = pc + {imm[31:12], 12'b0}`.
  - ADDI: `rd = rs1 + sext(imm12)`.
  - Loads: LB, LH, LW, LBU, LHU.
  - Stores: SB, SH, SW.
- Effective address: `ea = rs1 + sext(imm12)`, computed mod 2^32. Word index is `ea[log2(DATA_WORDS)+1:2]` and wraps modulo depth.
- Loads:
  - Byte lane is selected by `ea[1:0]`; halfword by `ea[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Misalignment is resolved by masking: LH/LHU ignore `ea[0]`; LW ignores `ea[1:0]`. No exception.
- Stores:
  - Byte enables: SB writes the lane `ea[1:0]` with `rs2[7:0]`.
  - SH writes lanes {1,0} or {3,2} selected by `ea[1]`, with `rs2[15:0]`. It ignores `ea[0]`.
  - SW writes all 4 lanes with `rs2`. It ignores `ea[1:0]`.
  - Unselected bytes are preserved.
- Any other opcode or funct3 is unsupported:
  - `illegal`=1 for that cycle.
  - No register or memory write.
  - PC still advances by 4.
- Next PC is always `pc + 4`, mod 2^32. No branches or jumps.

## Timing
- Single cycle per instruction. Fetch, decode, register read, address and data-memory read are combinational within the cycle.
- Register write and data-memory write commit at the rising edge ending the cycle. A result is visible on `dbg_data` in the next cycle.
- Data memory read is asynchronous. A load immediately following a store to the same word returns the newly stored data.
- Reset (`rst_n`=0 sampled at a rising edge):
  - `pc` ← `RESET_PC`.
  - All registers ← 0.
  - No memory write occurs in that cycle.
  - Memory contents are not cleared.
- Reset asserted mid-program aborts the in-flight instruction: its register or memory write is suppressed.
- Execution resumes at `RESET_PC` on the first rising edge with `rst_n`=1.
- Memories may be reloaded by the bench while `rst_n`=0.
- Fetch index wraps modulo `PROG_WORDS`, so PC beyond program memory re-executes from word 0.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with arbitrary register state.
  - Required: `pc`=0 and all `dbg_data` reads = 0.
  - Then release: `pc` steps 0, 4, 8.
- LUI/AUIPC: program `lui x1,0x12345; auipc x2,0x1`.
  - Required: x1=0x12345000, x2=0x00001004.
- Loads: `dataArray[0]=0x8000_80FF`, `dataArray[1]=0x1234_5678`; x1=0. Program: `lb x2,0(x1); lbu x3,0(x1); lh x4,2(x1); lhu x5,2(x1); lw x6,4(x1)`.
  - Required: x2=0xFFFFFFFF, x3=0x000000FF, x4=0xFFFF8000, x5=0x00008000, x6=0x12345678.
- Stores: `dataArray[0]=0xAABBCCDD`, x1=0, x2=0x11223344. Program: `sb x2,1(x1); sh x2,6(x1); sw x2,8(x1)`.
  - Required: `dataArray[0]`=0xAABB44DD; `dataArray[1]` upper half=0x3344 with lower half preserved; `dataArray[2]`=0x11223344.
- Store-then-load: `sw` then `lw` to the same address with no gap.
  - Required: the load returns the stored value. Writes to x0 leave x0 = 0.
- Illegal and reset mid-op: an all-zero instruction gives `illegal`=1 with no state change and `pc`+=4.
  - Asserting `rst_n`=0 during an `sw` cycle leaves the memory word unchanged.

Source files
------------

// File: rtl/rv32i_ldst_top_if.sv
// rv32i_ldst_top_if: observation bundle of the load/store core.
// Carries the debug register read port, the current PC and the unsupported-instruction flag.
interface rv32i_ldst_top_if;
    logic [4:0]  dbg_sel;
    logic [31:0] dbg_data;
    logic [31:0] pc;
    logic        illegal;

    modport master (
        output dbg_sel,
        input  dbg_data,
        input  pc,
        input  illegal
    );

    modport slave (
        input  dbg_sel,
        output dbg_data,
        output pc,
        output illegal
    );
endinterface

// File: rtl/rv32i_ldst_top.sv
// rv32i_ldst_top: single-cycle RV32I subset core (LUI, AUIPC, ADDI, loads, stores)
// with private word-indexed program and data memories and a debug observation interface.

module mem_prog #(
    parameter int PROG_WORDS = 256
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(PROG_WORDS)-1:0] idx,
    input  logic [31:0]                   wdata,
    output logic [31:0]                   rdata
);
    logic [31:0] progArray [0:PROG_WORDS-1];

    // Image write port; the core ties it off, so the array is only loaded from outside
    always_ff @(posedge clk) begin
        if (we) begin
            progArray[idx] <= wdata;
        end
    end

    assign rdata = progArray[idx];
endmodule

module mem_data #(
    parameter int DATA_WORDS = 256
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [3:0]                    be,
    input  logic [$clog2(DATA_WORDS)-1:0] idx,
    input  logic [31:0]                   wdata,
    output logic [31:0]                   rdata
);
    logic [31:0] dataArray [0:DATA_WORDS-1];

    // Byte-lane write; lanes without an enable keep their old contents
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    dataArray[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = dataArray[idx];
endmodule

module rv32i_ldst_top #(
    parameter int          PROG_WORDS = 256,
    parameter int          DATA_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    rv32i_ldst_top_if.slave dbg
);
    localparam int PIDX_W = $clog2(PROG_WORDS);
    localparam int DIDX_W = $clog2(DATA_WORDS);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    // Misaligned halfword/word accesses are resolved by ignoring the low address bits
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'h00_0000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    function automatic logic load_f3_ok(input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
            default:                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << lane;
            3'b001:  be = lane[1] ? 4'b1100 : 4'b0011;
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data is replicated across lanes so the byte enables alone pick the target
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] v);
        logic [31:0] d;
        case (f3)
            3'b000:  d = {4{v[7:0]}};
            3'b001:  d = {2{v[15:0]}};
            3'b010:  d = v;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    logic [31:0]       pc_r;
    logic [31:0]       regs_r [0:31];

    logic [31:0]       instr_s;
    logic [6:0]        opcode_s;
    logic [4:0]        rd_s;
    logic [4:0]        rs1_s;
    logic [4:0]        rs2_s;
    logic [2:0]        f3_s;
    logic [31:0]       rs1_val_s;
    logic [31:0]       rs2_val_s;
    logic [31:0]       imm_i_s;
    logic [31:0]       imm_s_s;
    logic [31:0]       imm_u_s;
    logic [31:0]       ea_s;
    logic [PIDX_W-1:0] pidx_s;
    logic [DIDX_W-1:0] didx_s;
    logic [31:0]       mem_rdata_s;
    logic [31:0]       wb_val_s;
    logic              rf_we_s;
    logic              rf_commit_s;
    logic              dmem_we_s;
    logic              dmem_commit_s;
    logic [3:0]        dmem_be_s;
    logic [31:0]       dmem_wdata_s;
    logic              illegal_s;

    assign pidx_s = PIDX_W'(pc_r[31:2]);

    mem_prog #(.PROG_WORDS(PROG_WORDS)) mem_prog_inst (
        .clk   (clk),
        .we    (1'b0),
        .idx   (pidx_s),
        .wdata (32'h0000_0000),
        .rdata (instr_s)
    );

    assign opcode_s  = instr_s[6:0];
    assign rd_s      = instr_s[11:7];
    assign f3_s      = instr_s[14:12];
    assign rs1_s     = instr_s[19:15];
    assign rs2_s     = instr_s[24:20];
    assign rs1_val_s = regs_r[rs1_s];
    assign rs2_val_s = regs_r[rs2_s];
    assign imm_i_s   = sext12(instr_s[31:20]);
    assign imm_s_s   = sext12({instr_s[31:25], instr_s[11:7]});
    assign imm_u_s   = {instr_s[31:12], 12'h000};

    assign ea_s   = rs1_val_s + ((opcode_s == OP_STORE) ? imm_s_s : imm_i_s);
    assign didx_s = DIDX_W'(ea_s[31:2]);

    mem_data #(.DATA_WORDS(DATA_WORDS)) mem_data_inst (
        .clk   (clk),
        .we    (dmem_commit_s),
        .be    (dmem_be_s),
        .idx   (didx_s),
        .wdata (dmem_wdata_s),
        .rdata (mem_rdata_s)
    );

    // Decode and execute: select the write-back value and the store lane pattern
    always_comb begin
        rf_we_s      = 1'b0;
        wb_val_s     = 32'h0000_0000;
        dmem_we_s    = 1'b0;
        dmem_be_s    = 4'b0000;
        dmem_wdata_s = 32'h0000_0000;
        illegal_s    = 1'b0;
        case (opcode_s)
            OP_LUI: begin
                rf_we_s  = 1'b1;
                wb_val_s = imm_u_s;
            end
            OP_AUIPC: begin
                rf_we_s  = 1'b1;
                wb_val_s = pc_r + imm_u_s;
            end
            OP_IMM: begin
                if (f3_s == 3'b000) begin
                    rf_we_s  = 1'b1;
                    wb_val_s = rs1_val_s + imm_i_s;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OP_LOAD: begin
                if (load_f3_ok(f3_s)) begin
                    rf_we_s  = 1'b1;
                    wb_val_s = load_extract(mem_rdata_s, f3_s, ea_s[1:0]);
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OP_STORE: begin
                if (f3_s <= 3'b010) begin
                    dmem_we_s    = 1'b1;
                    dmem_be_s    = store_be(f3_s, ea_s[1:0]);
                    dmem_wdata_s = store_data(f3_s, rs2_val_s);
                end else begin
                    illegal_s = 1'b1;
                end
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // A reset cycle aborts the in-flight instruction, including its memory write
    assign dmem_commit_s = dmem_we_s & rst_n;
    assign rf_commit_s   = rf_we_s & (rd_s != 5'd0);

    // PC and register file state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else begin
            pc_r <= pc_r + 32'd4;
            if (rf_commit_s) begin
                regs_r[rd_s] <= wb_val_s;
            end
        end
    end

    assign dbg.pc       = pc_r;
    assign dbg.illegal  = illegal_s;
    assign dbg.dbg_data = (dbg.dbg_sel == 5'd0) ? 32'h0000_0000 : regs_r[dbg.dbg_sel];
endmodule

// File: tb/tb_rv32i_ldst_top.sv
// tb_rv32i_ldst_top: directed and random programs for rv32i_ldst_top, checked against
// an instruction-level model that keeps data memory as a plain byte array.
module tb_rv32i_ldst_top;
    localparam int PW = 256;
    localparam int DW = 256;
    localparam int NB = DW * 4;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rv32i_ldst_top_if dbg_if ();

    rv32i_ldst_top #(
        .PROG_WORDS (PW),
        .DATA_WORDS (DW),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dbg   (dbg_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] tb_prog [0:PW-1];
    logic [7:0]  m_bytes [0:NB-1];
    logic [31:0] m_regs  [0:31];
    logic [31:0] m_pc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] model_word(input int w);
        return {m_bytes[4*w+3], m_bytes[4*w+2], m_bytes[4*w+1], m_bytes[4*w]};
    endfunction

    task automatic set_word(input int w, input logic [31:0] v);
        for (int i = 0; i < 4; i++) m_bytes[4*w+i] = v[8*i +: 8];
    endtask

    task automatic clear_prog();
        for (int i = 0; i < PW; i++) tb_prog[i] = 32'h0000_0000;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NB; i++) m_bytes[i] = 8'h00;
    endtask

    // Architectural effect of one instruction on the model state
    task automatic model_step(input logic [31:0] ins, output logic ill);
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] a_rs1, a_rs2, immi, imms, ea, res;
        int unsigned a;
        int          n;
        logic        wr;
        op    = ins[6:0];
        rd    = ins[11:7];
        f3    = ins[14:12];
        a_rs1 = m_regs[ins[19:15]];
        a_rs2 = m_regs[ins[24:20]];
        immi  = {{20{ins[31]}}, ins[31:20]};
        imms  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ill   = 1'b1;
        wr    = 1'b0;
        res   = 32'h0;
        if (op == OP_LUI) begin
            ill = 1'b0; wr = 1'b1; res = {ins[31:12], 12'h000};
        end else if (op == OP_AUIPC) begin
            ill = 1'b0; wr = 1'b1; res = m_pc + {ins[31:12], 12'h000};
        end else if (op == OP_IMM && f3 == 3'd0) begin
            ill = 1'b0; wr = 1'b1; res = a_rs1 + immi;
        end else if (op == OP_LOAD && f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
            ill = 1'b0; wr = 1'b1;
            ea  = a_rs1 + immi;
            a   = ea % NB;
            case (f3)
                3'd0: res = {{24{m_bytes[a][7]}}, m_bytes[a]};
                3'd4: res = {24'h0, m_bytes[a]};
                3'd1, 3'd5: begin
                    a   = a - a % 2;
                    res = {16'h0, m_bytes[a+1], m_bytes[a]};
                    if (f3 == 3'd1 && res[15]) res = res | 32'hFFFF_0000;
                end
                default: begin
                    a   = a - a % 4;
                    res = {m_bytes[a+3], m_bytes[a+2], m_bytes[a+1], m_bytes[a]};
                end
            endcase
        end else if (op == OP_STORE && f3 < 3'd3) begin
            ill = 1'b0;
            ea  = a_rs1 + imms;
            a   = ea % NB;
            n   = 1 << f3;
            a   = a - a % n;
            for (int i = 0; i < n; i++) m_bytes[a+i] = a_rs2[8*i +: 8];
        end
        if (wr && rd != 5'd0) m_regs[rd] = res;
        m_pc = m_pc + 32'd4;
    endtask

    task automatic read_reg(input int r, output logic [31:0] v);
        dbg_if.dbg_sel = 5'(r);
        #1;
        v = dbg_if.dbg_data;
    endtask

    // Load both memories under reset, hold reset for two edges, release on a falling edge
    task automatic load_and_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int w = 0; w < PW; w++) dut.mem_prog_inst.progArray[w] = tb_prog[w];
        for (int w = 0; w < DW; w++) dut.mem_data_inst.dataArray[w] = model_word(w);
        repeat (2) @(negedge clk);
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        m_pc  = 32'h0;
        rst_n = 1'b1;
    endtask

    task automatic run_prog(input int n, input string tag);
        logic [31:0] ins;
        logic        ill;
        for (int c = 0; c < n; c++) begin
            check_val({tag, " pc"}, dbg_if.pc, m_pc);
            ins = tb_prog[(m_pc >> 2) % PW];
            model_step(ins, ill);
            check_val({tag, " illegal"}, {31'h0, dbg_if.illegal}, {31'h0, ill});
            @(negedge clk);
        end
    endtask

    task automatic check_final(input string tag);
        logic [31:0] v;
        for (int w = 0; w < DW; w++)
            check_val({tag, " mem"}, dut.mem_data_inst.dataArray[w], model_word(w));
        for (int r = 0; r < 32; r++) begin
            read_reg(r, v);
            check_val({tag, " reg"}, v, m_regs[r]);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [2:0]  f3;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        imm = 12'($urandom);
        case ($urandom_range(0, 9))
            0: return enc_u(20'($urandom), rd, OP_LUI);
            1: return enc_u(20'($urandom), rd, OP_AUIPC);
            2, 3: return enc_i(imm, rs1, 3'd0, rd, OP_IMM);
            4, 5: begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
                return enc_i(imm, rs1, f3, rd, OP_LOAD);
            end
            6, 7: return enc_s(imm, rs2, rs1, 3'($urandom_range(0, 2)));
            8: begin
                case ($urandom_range(0, 3))
                    0: return 32'h0000_0000;
                    1: return enc_i(imm, rs1, 3'($urandom_range(1, 7)), rd, OP_IMM);
                    2: return enc_i(imm, rs1, 3'($urandom_range(6, 7)), rd, OP_LOAD);
                    default: return enc_s(imm, rs2, rs1, 3'($urandom_range(3, 7)));
                endcase
            end
            default: return enc_i(imm, 5'd0, 3'd0, rd, OP_IMM);
        endcase
    endfunction

    initial begin
        logic [31:0] v;
        dbg_if.dbg_sel = 5'd0;

        // LUI / AUIPC
        clear_prog(); clear_mem();
        tb_prog[0] = enc_u(20'h12345, 5'd1, OP_LUI);
        tb_prog[1] = enc_u(20'h00001, 5'd2, OP_AUIPC);
        load_and_reset();
        run_prog(2, "upper");
        read_reg(1, v); check_val("lui x1", v, 32'h1234_5000);
        read_reg(2, v); check_val("auipc x2", v, 32'h0000_1004);
        check_final("upper");

        // Loads with sign/zero extension and lane selection
        clear_prog(); clear_mem();
        set_word(0, 32'h8000_80FF);
        set_word(1, 32'h1234_5678);
        tb_prog[0] = enc_i(12'd0, 5'd1, 3'b000, 5'd2, OP_LOAD);
        tb_prog[1] = enc_i(12'd0, 5'd1, 3'b100, 5'd3, OP_LOAD);
        tb_prog[2] = enc_i(12'd2, 5'd1, 3'b001, 5'd4, OP_LOAD);
        tb_prog[3] = enc_i(12'd2, 5'd1, 3'b101, 5'd5, OP_LOAD);
        tb_prog[4] = enc_i(12'd4, 5'd1, 3'b010, 5'd6, OP_LOAD);
        load_and_reset();
        run_prog(5, "loads");
        read_reg(2, v); check_val("lb", v, 32'hFFFF_FFFF);
        read_reg(3, v); check_val("lbu", v, 32'h0000_00FF);
        read_reg(4, v); check_val("lh", v, 32'hFFFF_8000);
        read_reg(5, v); check_val("lhu", v, 32'h0000_8000);
        read_reg(6, v); check_val("lw", v, 32'h1234_5678);
        check_final("loads");

        // Stores preserve unselected lanes
        clear_prog(); clear_mem();
        set_word(0, 32'hAABB_CCDD);
        set_word(1, 32'h5566_7788);
        tb_prog[0] = enc_u(20'h11223, 5'd2, OP_LUI);
        tb_prog[1] = enc_i(12'h344, 5'd2, 3'b000, 5'd2, OP_IMM);
        tb_prog[2] = enc_s(12'd1, 5'd2, 5'd1, 3'b000);
        tb_prog[3] = enc_s(12'd6, 5'd2, 5'd1, 3'b001);
        tb_prog[4] = enc_s(12'd8, 5'd2, 5'd1, 3'b010);
        load_and_reset();
        run_prog(5, "stores");
        check_val("sb word0", dut.mem_data_inst.dataArray[0], 32'hAABB_44DD);
        check_val("sh word1", dut.mem_data_inst.dataArray[1], 32'h3344_7788);
        check_val("sw word2", dut.mem_data_inst.dataArray[2], 32'h1122_3344);
        check_final("stores");

        // Store immediately followed by load of the same word; x0 stays zero
        clear_prog(); clear_mem();
        tb_prog[0] = enc_u(20'hDEADB, 5'd3, OP_LUI);
        tb_prog[1] = enc_i(12'hEEF, 5'd3, 3'b000, 5'd3, OP_IMM);
        tb_prog[2] = enc_s(12'd12, 5'd3, 5'd0, 3'b010);
        tb_prog[3] = enc_i(12'd12, 5'd0, 3'b010, 5'd4, OP_LOAD);
        tb_prog[4] = enc_i(12'd12, 5'd0, 3'b010, 5'd0, OP_LOAD);
        tb_prog[5] = enc_i(12'd5, 5'd0, 3'b000, 5'd0, OP_IMM);
        load_and_reset();
        run_prog(6, "st_ld");
        read_reg(4, v); check_val("st-ld x4", v, 32'hDEAD_AEEF);
        read_reg(0, v); check_val("x0 zero", v, 32'h0000_0000);
        check_final("st_ld");

        // All-zero instruction is unsupported and changes nothing
        clear_prog(); clear_mem();
        tb_prog[0] = enc_i(12'd7, 5'd0, 3'b000, 5'd1, OP_IMM);
        tb_prog[2] = enc_i(12'd1, 5'd1, 3'b000, 5'd2, OP_IMM);
        load_and_reset();
        run_prog(1, "illegal");
        check_val("illegal flag", {31'h0, dbg_if.illegal}, 32'h0000_0001);
        check_val("illegal pc", dbg_if.pc, 32'h0000_0004);
        run_prog(2, "illegal");
        read_reg(1, v); check_val("illegal x1", v, 32'h0000_0007);
        read_reg(2, v); check_val("illegal x2", v, 32'h0000_0008);
        check_final("illegal");

        // Fetch wraps modulo program depth
        clear_prog(); clear_mem();
        tb_prog[0] = enc_i(12'd1, 5'd1, 3'b000, 5'd1, OP_IMM);
        load_and_reset();
        run_prog(PW + 1, "wrap");
        read_reg(1, v); check_val("wrap x1", v, 32'h0000_0002);

        // Reset asserted during a store cycle suppresses the write
        clear_prog(); clear_mem();
        set_word(4, 32'h0BAD_F00D);
        tb_prog[0] = enc_u(20'h12345, 5'd2, OP_LUI);
        tb_prog[1] = enc_s(12'd16, 5'd2, 5'd0, 3'b010);
        load_and_reset();
        run_prog(1, "rst_sw");
        rst_n = 1'b0;
        @(negedge clk);
        check_val("rst_sw mem", dut.mem_data_inst.dataArray[4], 32'h0BAD_F00D);
        check_val("rst_sw pc", dbg_if.pc, 32'h0000_0000);
        read_reg(2, v); check_val("rst_sw x2", v, 32'h0000_0000);

        // Random programs against the model
        for (int t = 0; t < 6; t++) begin
            clear_prog();
            for (int i = 0; i < NB; i++) m_bytes[i] = 8'($urandom);
            for (int i = 0; i < 48; i++) tb_prog[i] = rand_instr();
            load_and_reset();
            run_prog(48, "rand");
            check_final("rand");
        end

        // Reset from arbitrary register state, then PC stepping
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("reset pc", dbg_if.pc, 32'h0000_0000);
        for (int r = 0; r < 32; r++) begin
            read_reg(r, v);
            check_val("reset reg", v, 32'h0000_0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_val("release pc0", dbg_if.pc, 32'h0000_0000);
        @(negedge clk);
        check_val("release pc4", dbg_if.pc, 32'h0000_0004);
        @(negedge clk);
        check_val("release pc8", dbg_if.pc, 32'h0000_0008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
